// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants for the DVI/TMDS encoder.
//   - Control tokens sent during blanking, selected by the control pair C.
//   - Width of the running-disparity counter (two's complement).
//   - Colour-bar table for the optional test pattern ({red, green, blue}).
//   - control_token(): maps C to its 10-bit token.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'h354;
  localparam logic [9:0] TOKEN_C01 = 10'h0AB;
  localparam logic [9:0] TOKEN_C10 = 10'h154;
  localparam logic [9:0] TOKEN_C11 = 10'h2AB;

  // Disparity stays within -8..+8, so 5 signed bits are enough.
  localparam int CNT_W = 5;

  // Entry 0 is the leftmost bar. Concatenation lists entry 7 first.
  localparam logic [7:0][23:0] BAR_COLOURS = {
    24'h000000,  // 7 black
    24'h0000FF,  // 6 blue
    24'hFF0000,  // 5 red
    24'hFF00FF,  // 4 magenta
    24'h00FF00,  // 3 green
    24'h00FFFF,  // 2 cyan
    24'hFFFF00,  // 1 yellow
    24'hFFFFFF   // 0 white
  };

  function automatic logic [9:0] control_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = TOKEN_C00;
      2'b01:   tok = TOKEN_C01;
      2'b10:   tok = TOKEN_C10;
      default: tok = TOKEN_C11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// tmds_channel: one DVI TMDS encoder lane (8b -> 10b, DC balanced).
//   Stage 1 registers the transition-minimised word q_m and its ones count.
//   Stage 2 registers the output symbol and the running disparity cnt.
// Ports:
//   clk, reset_n  pixel clock, asynchronous active-low reset
//   data          8-bit pixel component (undelayed)
//   de_q          data_enable already delayed by one clock (aligned with q_m)
//   c_q           control pair already delayed by one clock
//   tmds          10-bit symbol, bit 0 transmitted first
// No handshake: a symbol is produced every clock, latency 2 from data.
module tmds_channel
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       de_q,
  input  logic [1:0] c_q,
  output logic [9:0] tmds
);

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0] n1_data;
  logic       use_xnor;
  logic [8:0] q_m_next;
  logic [3:0] n1_qm_next;
  logic [8:0] q_m;
  logic [3:0] n1q;

  always_comb begin
    n1_data = 4'd0;
    for (int i = 0; i < 8; i++) n1_data = n1_data + {3'd0, data[i]};
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
    q_m_next    = 9'd0;
    q_m_next[0] = data[0];
    for (int i = 1; i < 8; i++)
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i]) : (q_m_next[i-1] ^ data[i]);
    q_m_next[8] = ~use_xnor;
    n1_qm_next = 4'd0;
    for (int i = 0; i < 8; i++) n1_qm_next = n1_qm_next + {3'd0, q_m_next[i]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_m <= 9'd0;
      n1q <= 4'd0;
    end else begin
      q_m <= q_m_next;
      n1q <= n1_qm_next;
    end
  end

  // ---------------- stage 2: DC balance ----------------
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_next;
  logic signed [CNT_W-1:0] diff;  // N1q - N0q
  logic [9:0] sym_next;
  logic       cnt_pos;
  logic       cnt_neg;

  always_comb begin
    // N0q = 8 - N1q, so N1q - N0q = 2*N1q - 8 (range -8..+8).
    diff     = $signed({n1q, 1'b0} - 5'd8);
    cnt_neg  = cnt[CNT_W-1];
    cnt_pos  = !cnt[CNT_W-1] && (cnt != '0);
    sym_next = TOKEN_C00;
    cnt_next = cnt;
    if (!de_q) begin
      // Blanking: control token, disparity restarts from zero.
      sym_next = control_token(c_q);
      cnt_next = '0;
    end else if ((cnt == '0) || (n1q == 4'd4)) begin
      sym_next = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
      sym_next = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym_next = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmds <= TOKEN_C00;
      cnt  <= '0;
    end else begin
      tmds <= sym_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: 24-bit RGB + sync/enable -> three DVI TMDS symbols per clock.
// Ports:
//   clk            pixel clock (same as the video controller's pixel_clk)
//   reset_n        asynchronous active-low reset
//   data_red/green/blue  8-bit pixel components
//   data_enable    1 = active video, 0 = blanking
//   hSync, vSync   sync strobes, polarity already adjusted
//   test_pattern   selects internal colour bars (only with TMDS_TEST_PATTERN_EN)
//   tmds_red/green/blue  10-bit symbols for channels 2/1/0, bit 0 first
// Parameter BAR_WIDTH: pixel width of each test-pattern bar.
// Optional feature: define TMDS_TEST_PATTERN_EN to build the colour-bar
// generator; otherwise test_pattern is ignored and no counters exist.
// No handshake: one symbol per channel every clock, fixed latency 2.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int BAR_WIDTH = 80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_red,
  input  logic [7:0] data_green,
  input  logic [7:0] data_blue,
  input  logic       data_enable,
  input  logic       hSync,
  input  logic       vSync,
  input  logic       test_pattern,
  output logic [9:0] tmds_red,
  output logic [9:0] tmds_green,
  output logic [9:0] tmds_blue
);

  logic [23:0] rgb;  // {red, green, blue} entering stage 1

`ifdef TMDS_TEST_PATTERN_EN
  localparam int PIX_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

  logic [PIX_W-1:0] pix_cnt;
  logic [2:0]       bar_idx;

  // Counters run only during active video and restart every blanking
  // interval; the bar index saturates on the last (black) bar.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (!data_enable) begin
      pix_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (pix_cnt == PIX_W'(BAR_WIDTH - 1)) begin
      pix_cnt <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

  assign rgb = test_pattern ? BAR_COLOURS[bar_idx] : {data_red, data_green, data_blue};
`else
  localparam int unused_bar_width = BAR_WIDTH;
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign rgb = {data_red, data_green, data_blue};
`endif

  // data_enable and the blue control pair travel alongside stage 1.
  logic       de_q;
  logic [1:0] c_blue_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q     <= 1'b0;
      c_blue_q <= 2'b00;
    end else begin
      de_q     <= data_enable;
      c_blue_q <= {vSync, hSync};
    end
  end

  tmds_channel u_red (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (rgb[23:16]),
    .de_q    (de_q),
    .c_q     (2'b00),
    .tmds    (tmds_red)
  );

  tmds_channel u_green (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (rgb[15:8]),
    .de_q    (de_q),
    .c_q     (2'b00),
    .tmds    (tmds_green)
  );

  tmds_channel u_blue (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (rgb[7:0]),
    .de_q    (de_q),
    .c_q     (c_blue_q),
    .tmds    (tmds_blue)
  );

endmodule

// File: tb/tb_tmds_encoder.sv
// Testbench for tmds_encoder: directed symbol vectors, a decoding check of
// random pixels, reset behaviour and (when built with TMDS_TEST_PATTERN_EN)
// the colour bars. Expected responses are queued at issue time and popped by
// a separate monitor two clocks later.
module tb_tmds_encoder;

  localparam int BAR_W = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_red, data_green, data_blue;
  logic       data_enable, hSync, vSync, test_pattern;
  logic [9:0] tmds_red, tmds_green, tmds_blue;

  always #5 clk = ~clk;

  tmds_encoder #(.BAR_WIDTH(BAR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_red     (data_red),
    .data_green   (data_green),
    .data_blue    (data_blue),
    .data_enable  (data_enable),
    .hSync        (hSync),
    .vSync        (vSync),
    .test_pattern (test_pattern),
    .tmds_red     (tmds_red),
    .tmds_green   (tmds_green),
    .tmds_blue    (tmds_blue)
  );

  // ---------------- scoreboard state ----------------
  // Entry: {kind, de, c[1:0], rgb[23:0], sym[29:0]}
  //   kind 0: compare {red,green,blue} symbols against sym
  //   kind 1: decode symbols and compare against rgb (or token for c)
  logic [57:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic tag = 1'b0;
  logic tag_d1, tag_d2;
  int disp[3];

  // Marks which output cycles carry a queued expectation (two-clock latency).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_d1 <= 1'b0;
      tag_d2 <= 1'b0;
    end else begin
      tag_d1 <= tag;
      tag_d2 <= tag_d1;
    end
  end

  function automatic logic [9:0] token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      default: t = 10'h2AB;
    endcase
    return t;
  endfunction

  function automatic logic is_token(input logic [9:0] s);
    return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] t;
    logic [7:0] d;
    t = s[9] ? ~s[7:0] : s[7:0];
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return d;
  endfunction

  function automatic logic [23:0] bar_colour(input int idx);
    logic [23:0] c;
    case (idx)
      0:       c = 24'hFFFFFF;
      1:       c = 24'hFFFF00;
      2:       c = 24'h00FFFF;
      3:       c = 24'h00FF00;
      4:       c = 24'hFF00FF;
      5:       c = 24'hFF0000;
      6:       c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic [29:0] all3(input logic [9:0] s);
    return {s, s, s};
  endfunction

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name, input int d);
    checks++;
    if (d > 8 || d < -8) begin
      failures++;
      $display("FAIL %s actual=%0d required=-8..8", name, d);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [57:0] e;
    logic [9:0]  s[3];
    forever begin
      @(negedge clk);
      s[0] = tmds_red;
      s[1] = tmds_green;
      s[2] = tmds_blue;
      // Running disparity of the transmitted stream, restarted by tokens.
      for (int ch = 0; ch < 3; ch++) begin
        if (!reset_n || is_token(s[ch])) disp[ch] = 0;
        else disp[ch] = disp[ch] + 2 * $countones(s[ch]) - 10;
      end
      if (reset_n && tag_d2) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 30'd1, 30'd0);
        end else begin
          e = exp_q.pop_front();
          if (!e[57]) begin
            check("symbols", {s[0], s[1], s[2]}, e[29:0]);
          end else if (e[56]) begin
            check("decoded_rgb", {10'd0, decode(s[0]), decode(s[1]), decode(s[2])},
                  {10'd0, e[53:30]});
            check_disp("disp_red", disp[0]);
            check_disp("disp_green", disp[1]);
            check_disp("disp_blue", disp[2]);
          end else begin
            check("blank_tokens", {s[0], s[1], s[2]}, {10'h354, 10'h354, token(e[55:54])});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic de, input logic [1:0] c, input logic [23:0] rgb_in,
                       input logic tp, input logic chk, input logic kind,
                       input logic [23:0] exp_rgb, input logic [29:0] exp_sym);
    @(posedge clk);
    #1;
    data_enable = de;
    vSync = c[1];
    hSync = c[0];
    {data_red, data_green, data_blue} = rgb_in;
    test_pattern = tp;
    tag = chk;
    if (chk) exp_q.push_back({kind, de, c, exp_rgb, exp_sym});
  endtask

  task automatic send_sym(input logic de, input logic [1:0] c, input logic [23:0] rgb,
                          input logic [29:0] sym);
    drive(de, c, rgb, 1'b0, 1'b1, 1'b0, rgb, sym);
  endtask

  task automatic send_dec(input logic de, input logic [1:0] c, input logic [23:0] rgb);
    drive(de, c, rgb, 1'b0, 1'b1, 1'b1, rgb, 30'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0, 30'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    data_enable = 1'b0;
    hSync = 1'b0;
    vSync = 1'b0;
    test_pattern = 1'b0;
    {data_red, data_green, data_blue} = 24'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {tmds_red, tmds_green, tmds_blue}, all3(10'h354));
    reset_n = 1'b1;

    // Blanking after release keeps the 00 token.
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));

    // Control tokens on blue, C = {vSync, hSync}.
    send_sym(1'b0, 2'b00, 24'h123456, {10'h354, 10'h354, 10'h354});
    send_sym(1'b0, 2'b01, 24'h123456, {10'h354, 10'h354, 10'h0AB});
    send_sym(1'b0, 2'b10, 24'h123456, {10'h354, 10'h354, 10'h154});
    send_sym(1'b0, 2'b11, 24'h123456, {10'h354, 10'h354, 10'h2AB});

    // Repeated black from cnt=0: disparity -8, +2, -6.
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h100));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h3FF));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h100));

    // White from cnt=0 (-> -8), then white again taking the plain path (-> -2).
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));
    send_sym(1'b1, 2'b00, 24'hFFFFFF, all3(10'h200));
    send_sym(1'b1, 2'b00, 24'hFFFFFF, all3(10'h0FF));

    // Single-cycle blank inside active video clears the disparity.
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h100));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h3FF));
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h100));

    // Independent channels: red 0x55 balanced, green 0x01 swings +8 then +2.
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));
    send_sym(1'b1, 2'b00, 24'h550100, {10'h133, 10'h1FF, 10'h100});
    send_sym(1'b1, 2'b00, 24'h550100, {10'h133, 10'h300, 10'h3FF});
    send_sym(1'b0, 2'b10, 24'h000000, {10'h354, 10'h354, 10'h154});

    // Random pixels and syncs, checked through a decoder.
    for (int i = 0; i < 10000; i++)
      send_dec(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 24'($urandom));

`ifdef TMDS_TEST_PATTERN_EN
    send_dec(1'b0, 2'b00, 24'd0);
    send_dec(1'b0, 2'b00, 24'd0);
    for (int p = 0; p < 40; p++)
      drive(1'b1, 2'($urandom_range(0, 3)), 24'($urandom), 1'b1, 1'b1, 1'b1,
            bar_colour((p / BAR_W > 7) ? 7 : p / BAR_W), 30'd0);
    send_dec(1'b0, 2'b00, 24'd0);
`endif

    // Reset in the middle of active video: outputs go to the 00 token at once.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b00, 24'($urandom), 1'b0, 1'b0, 1'b0, 24'd0, 30'd0);
    idle(3);
    drive(1'b1, 2'b01, 24'hA5C3F0, 1'b0, 1'b0, 1'b0, 24'd0, 30'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_midline", {tmds_red, tmds_green, tmds_blue}, all3(10'h354));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    data_enable = 1'b0;
    send_sym(1'b0, 2'b00, 24'h000000, all3(10'h354));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h100));
    send_sym(1'b1, 2'b00, 24'h000000, all3(10'h3FF));

    idle(4);
    check("queue_drained", 30'(exp_q.size()), 30'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
